// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, data width, baud divider helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

    // System clocks per line bit, truncating; also used by the receiver.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_done on the last clock of every CLKS_PER_BIT window.
// Latency: first bit_done CLKS_PER_BIT cycles after the edge that sampled restart.
// Backpressure: none; free-running between restarts.
// Ports: clk, rst (async, active-high), restart (realign window to start now),
//        bit_done (last cycle of a bit), bit_done_next (next cycle will be the last).
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done,
    output logic bit_done_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done      = (cnt_q == CNT_LAST);
    // Look-ahead lets the owner register a signal that is valid in the last cycle.
    assign bit_done_next = (cnt_d == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, 1 or 2 stop bits, idle-high line.
// Latency: uart_txd drops one cycle after the handshake edge; frame = (9+STOP_BITS) bit times.
// Backpressure: tx_ready high only in IDLE and the last cycle of the last stop bit.
// Ports: clk, rst (async, active-high), tx_data/tx_valid/tx_ready (byte stream in),
//        tx_busy (frame on the line), uart_txd (serial out, straight from a flop).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int STOP_BITS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx_busy,
    output logic                      uart_txd
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_divider
        $fatal(1, "uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                idx_q, idx_d;    // data bit index, reused as stop bit index
    logic                      txd_q, txd_d;
    logic                      busy_q, busy_d;
    logic                      ready_q, ready_d;

    logic handshake;
    logic bit_done;
    logic bit_done_next;

    assign handshake = tx_valid && ready_q;

    // Restarting on the handshake aligns every frame to its own acceptance edge.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk           (clk),
        .rst           (rst),
        .restart       (handshake),
        .bit_done      (bit_done),
        .bit_done_next (bit_done_next)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        txd_d   = txd_q;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (handshake) begin
                    state_d = START;
                    txd_d   = 1'b0;
                    shift_d = tx_data;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == LAST_DATA) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                        idx_d   = '0;
                    end else begin
                        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        txd_d   = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (bit_done) begin
                    if (idx_q == LAST_STOP) begin
                        if (handshake) begin
                            // Back-to-back: next start bit follows with no idle gap.
                            state_d = START;
                            txd_d   = 1'b0;
                            shift_d = tx_data;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                idx_d   = '0;
            end
        endcase

        busy_d  = (state_d != IDLE);
        // Registered ready must already be high during the final stop cycle.
        ready_d = (state_d == IDLE) ||
                  ((state_d == STOP) && (idx_d == LAST_STOP) && bit_done_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serialises bytes to the UART transmit pin using 8N1 framing, or 8N2 when STOP_BITS=2.
- Sits directly downstream of skid_buffer and consumes its rd_data/rd_valid/rd_ready stream.
- The full TX path is fifo_sync -> skid_buffer -> uart_tx -> pin.
- Single clock domain; bit timing is derived from the system clock by an integer divider.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- STOP_BITS, 1: number of stop bits; legal values are 1 and 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- tx_data  input  8  byte to send; connects to skid_buffer rd_data.
- tx_valid  input  1  tx_data valid; connects to skid_buffer rd_valid.
- tx_ready  output  1  block can accept a byte this cycle; connects to skid_buffer rd_ready.
- tx_busy  output  1  a frame is in progress on the line.
- uart_txd  output  1  serial line; idle level is high.

Behaviour:
- CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, truncating.
- Elaboration fails with $fatal if CLKS_PER_BIT < 2 or if STOP_BITS is not 1 or 2.
- Bit counter width is $clog2(CLKS_PER_BIT).
- Reset (asynchronous assert, registers cleared immediately):
  - state = IDLE.
  - uart_txd = 1, tx_ready = 0, tx_busy = 0.
  - Shift register and counters = 0.
- tx_ready is registered. It rises on the first clk edge after rst deasserts.
- Handshake: a byte is accepted on any rising edge where tx_valid && tx_ready.
  - tx_data is captured into an 8-bit shift register on that edge.
  - The block never reads tx_data outside the handshake edge.
- tx_ready is high in IDLE. It is also high in the final clock of the final stop bit; everywhere else it is low.
- FSM states:
  - IDLE:
    - uart_txd = 1, tx_busy = 0.
    - On handshake -> START; uart_txd goes 0 and tx_busy goes 1 on the same edge (registered output, one-cycle latency from handshake).
  - START:
    - uart_txd = 0 for exactly CLKS_PER_BIT cycles, then -> DATA.
  - DATA:
    - 8 bits, LSB first; each bit is held CLKS_PER_BIT cycles.
    - The shift register shifts right at each bit boundary.
    - A 3-bit index counts 0..7; after bit 7 -> STOP.
  - STOP:
    - uart_txd = 1 for STOP_BITS*CLKS_PER_BIT cycles.
    - In the final cycle, tx_ready = 1.
    - Handshake in that cycle -> START directly (back-to-back, no idle gap).
    - No handshake -> IDLE.
- Frame period for back-to-back bytes is exactly (9+STOP_BITS)*CLKS_PER_BIT cycles.
- After an isolated frame, tx_busy = 0 from the edge that enters IDLE.
- The bit-timer restarts at 0 on every handshake, so frames align to the handshake and not to a free-running tick.
- tx_valid low during a frame has no effect.
- tx_valid low in IDLE: the FSM holds IDLE indefinitely.
- Reset mid-frame: the frame is abandoned immediately and uart_txd returns high asynchronously. The byte is lost. The upstream FIFO is also reset, so no resynchronisation is required.
- Unknown or illegal state encoding: recover to IDLE with uart_txd = 1.
- Glitch-free output: uart_txd is driven straight from a flop.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, STOP};
  - UART_DATA_BITS = 8;
  - the function clks_per_bit(clk_freq, baud_rate), shared with the future uart_rx.
- One sub-module, uart_bit_timer:
  - parameter CLKS_PER_BIT;
  - inputs clk, rst, restart;
  - output bit_done, a one-cycle pulse every CLKS_PER_BIT cycles after restart.
- The FSM and shift register live in uart_tx.

Test Plan:
- All tests use CLK_FREQ=100_000_000 and BAUD_RATE=10_000_000, giving CLKS_PER_BIT=10.
- Reset: hold rst 10 cycles with tx_valid=1 -> uart_txd=1, tx_ready=0, tx_busy=0 throughout; tx_ready=1 on the first edge after release; no frame starts before that.
- Single byte 0xA5: -> uart_txd low for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles; tx_busy high for exactly 100 cycles; tx_ready low for 99 cycles after the handshake.
- Back-to-back 0x00 then 0xFF with tx_valid held high: -> second start bit begins exactly 100 cycles after the first; no idle-high gap; decoded bytes 0x00, 0xFF.
- STOP_BITS=2, byte 0x3C: -> stop level lasts 20 cycles; back-to-back frame period is 110 cycles.
- Reset mid-frame: assert rst 35 cycles into the frame of 0x5A -> uart_txd=1 within the same cycle (asynchronous); after release, a new byte 0x81 transmits correctly.
- Integration: fifo_sync + skid_buffer + uart_tx; write 16 random bytes into the FIFO.
  - Bench UART monitor samples at bit centres.
  - Required: received queue equals written queue; 16 frames; no framing errors.
